serial_sub16: RTL and testbench



---
 rtl/serial_sub16_pkg.sv | 14 +
 rtl/serial_sub16_if.sv | 29 ++
 rtl/serial_sub16_subtractor4.sv | 22 ++
 rtl/serial_sub16.sv | 122 ++++++++++++
 tb/tb_serial_sub16.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/serial_sub16_pkg.sv
// rtl/serial_sub16_pkg.sv - shared types and constants for the nibble-serial subtractor
package sub_pkg;

  // Nibble width of the ripple-borrow slice
  localparam int NIB_W = 4;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_sub16_if.sv
// rtl/serial_sub16_if.sv - start/done handshake and operand/result bundle
interface serial_sub16_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             v;
  logic             z;
  logic             n;

  // Requesting side (datapath control FSM)
  modport master (
    output start, a, b,
    input  busy, done, d, bo, v, z, n
  );

  // Subtractor side
  modport slave (
    input  start, a, b,
    output busy, done, d, bo, v, z, n
  );

endinterface

// File: rtl/serial_sub16_subtractor4.sv
// rtl/serial_sub16_subtractor4.sv - combinational 4-bit ripple-borrow subtractor slice
module subtractor4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       b_in,
  output logic [3:0] S,
  output logic       b_out
);

  logic [4:0] bc;

  assign bc[0] = b_in;

  // Four chained full-subtractor cells, borrow rippling from bit 0 upward
  for (genvar i = 0; i < 4; i++) begin : g_cell
    assign S[i]    = A[i] ^ B[i] ^ bc[i];
    assign bc[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bc[i]);
  end

  assign b_out = bc[4];

endmodule

// File: rtl/serial_sub16.sv
// rtl/serial_sub16.sv - nibble-serial two's-complement subtractor with start/done handshake
module serial_sub16
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  serial_sub16_if.slave bus
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam int MSB     = WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_next;
  logic             borrow;
  logic [IDX_W-1:0] idx;
  logic [IDX_W+1:0] base;
  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] d4;
  logic             bout;
  logic             busy_q;
  logic             done_q;
  logic             bo_q;
  logic             v_q;
  logic             z_q;
  logic             n_q;

  // Bit offset of the current nibble (idx * 4)
  assign base = {idx, 2'b00};

  // Select the active operand nibbles and form the result with that nibble replaced
  always_comb begin
    a_nib  = a_q[base +: NIB_W];
    b_nib  = b_q[base +: NIB_W];
    d_next = d_q;
    d_next[base +: NIB_W] = d4;
  end

  subtractor4 u_slice (
    .A     (a_nib),
    .B     (b_nib),
    .b_in  (borrow),
    .S     (d4),
    .b_out (bout)
  );

  // Controller: accept, step one nibble per cycle, publish flags on the last nibble
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bo_q   <= 1'b0;
      v_q    <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            d_q    <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            bo_q   <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          d_q    <= d_next;
          borrow <= bout;
          idx    <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            bo_q   <= bout;
            n_q    <= d4[NIB_W-1];
            z_q    <= (d_next == '0);
            v_q    <= (a_q[MSB] ^ b_q[MSB]) & (d4[NIB_W-1] ^ a_q[MSB]);
            state  <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bo   = bo_q;
  assign bus.v    = v_q;
  assign bus.z    = z_q;
  assign bus.n    = n_q;

endmodule

// File: tb/tb_serial_sub16.sv
// tb/tb_serial_sub16.sv - self-checking bench for serial_sub16
module tb_serial_sub16;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  exp_t last_exp;

  serial_sub16_if #(.WIDTH(W)) bus ();

  serial_sub16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive a request at the current negedge and push the reference result
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] full;
    exp_t e;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    full = {1'b0, a} - {1'b0, b};
    e.d  = full[W-1:0];
    e.bo = full[W];
    e.v  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    e.z  = (full[W-1:0] == '0);
    e.n  = full[W-1];
    sb.push_back(e);
  endtask

  // Follow one operation from the cycle after its Start edge through Done
  task automatic run_check(input string tag, input bit inject, input bit chain,
                           input logic [W-1:0] ca, input logic [W-1:0] cb);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start = 1'b0;
        check({tag, " d_cleared"}, 32'(bus.d), 32'h0);
      end
      check({tag, " busy"}, 32'(bus.busy), 32'h1);
      check({tag, " done_early"}, 32'(bus.done), 32'h0);
      if (inject && k == 1) begin
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h1111;
      end
      if (inject && k == 2) bus.start = 1'b0;
    end
    @(negedge clk);
    check({tag, " done"}, 32'(bus.done), 32'h1);
    check({tag, " busy_off"}, 32'(bus.busy), 32'h0);
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      last_exp = e;
      check({tag, " d"}, 32'(bus.d), 32'(e.d));
      check({tag, " bo"}, 32'(bus.bo), 32'(e.bo));
      check({tag, " v"}, 32'(bus.v), 32'(e.v));
      check({tag, " z"}, 32'(bus.z), 32'(e.z));
      check({tag, " n"}, 32'(bus.n), 32'(e.n));
    end
    if (chain) begin
      issue(ca, cb);
    end else begin
      @(negedge clk);
      check({tag, " done_pulse"}, 32'(bus.done), 32'h0);
      check({tag, " busy_idle"}, 32'(bus.busy), 32'h0);
      check({tag, " d_held"}, 32'(bus.d), 32'(last_exp.d));
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'h0);
    check("rst done", 32'(bus.done), 32'h0);
    check("rst d", 32'(bus.d), 32'h0);
    check("rst flags", 32'({bus.bo, bus.v, bus.z, bus.n}), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Basic subtract with ignored mid-RUN Start, then back-to-back Start in DONE
    issue(16'h1234, 16'h0234);
    run_check("t1", 1'b1, 1'b1, 16'h0005, 16'h0007);
    run_check("t1b", 1'b0, 1'b0, '0, '0);

    issue(16'h1000, 16'h0001);
    run_check("ripple", 1'b0, 1'b0, '0, '0);

    issue(16'h0000, 16'h0001);
    run_check("under", 1'b0, 1'b0, '0, '0);

    issue(16'h8000, 16'h0001);
    run_check("ovf", 1'b0, 1'b0, '0, '0);

    issue(16'hABCD, 16'hABCD);
    run_check("zero", 1'b0, 1'b0, '0, '0);

    issue(16'h7FFF, 16'hFFFF);
    run_check("ovf2", 1'b0, 1'b0, '0, '0);

    // Reset asserted so that it is sampled at E2 of a running operation
    issue(16'h1234, 16'h0234);
    void'(sb.pop_back());
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst busy", 32'(bus.busy), 32'h0);
    check("mrst done", 32'(bus.done), 32'h0);
    check("mrst d", 32'(bus.d), 32'h0);
    check("mrst flags", 32'({bus.bo, bus.v, bus.z, bus.n}), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mrst no_done", 32'(bus.done), 32'h0);
      check("mrst no_busy", 32'(bus.busy), 32'h0);
    end

    issue(16'h4321, 16'h1234);
    run_check("post_rst", 1'b0, 1'b0, '0, '0);

    check("sb drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
